// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS core.
// Optional: FETCH_DELAY_SLOT_EN keeps the instruction behind a redirect (branch delay slot).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] imemRd,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcSrcD,
    input  logic [31:0] pcBranchD,
    input  logic        jumpD,
    output logic [31:0] imemAddr,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcPlus4D,
    output logic [5:0]  opD,
    output logic [5:0]  functD,
    output logic        validD
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] pc_plus4_f;
    logic [31:0] jump_tgt;
    logic        redirect;
    logic        flush;

    always_comb begin
        pc_plus4_f = pc_q + 32'd4;
        jump_tgt   = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
        // A redirect seen while ID is stalled belongs to a held instruction; re-evaluated later.
        redirect   = (jumpD | pcSrcD) & ~stallD;
`ifdef FETCH_DELAY_SLOT_EN
        flush      = 1'b0;
`else
        flush      = redirect;
`endif
    end

    always_comb begin
        pc_d = pc_plus4_f;
        if (stallF) begin
            pc_d = pc_q;
        end else if (jumpD && !stallD) begin
            pc_d = jump_tgt;
        end else if (pcSrcD && !stallD) begin
            pc_d = pcBranchD;
        end
    end

    always_comb begin
        id_instr_d    = imemRd;
        id_pc_plus4_d = pc_plus4_f;
        id_valid_d    = 1'b1;
        if (stallD) begin
            id_instr_d    = id_instr_q;
            id_pc_plus4_d = id_pc_plus4_q;
            id_valid_d    = id_valid_q;
        end else if (flush) begin
            id_instr_d    = NOP_INSTR;
            id_pc_plus4_d = '0;
            id_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= '0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
        end
    end

    assign pcF      = pc_q;
    assign imemAddr = pc_q;
    assign instrD   = id_instr_q;
    assign pcPlus4D = id_pc_plus4_q;
    assign validD   = id_valid_q;
    assign opD      = id_instr_q[31:26];
    assign functD   = id_instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expectations follow FETCH_DELAY_SLOT_EN when defined.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic [31:0] imemRd;
    logic        stallF, stallD, pcSrcD, jumpD;
    logic [31:0] pcBranchD;
    logic [31:0] imemAddr, pcF, instrD, pcPlus4D;
    logic [5:0]  opD, functD;
    logic        validD;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rstN(rstN), .imemRd(imemRd), .stallF(stallF), .stallD(stallD),
        .pcSrcD(pcSrcD), .pcBranchD(pcBranchD), .jumpD(jumpD), .imemAddr(imemAddr),
        .pcF(pcF), .instrD(instrD), .pcPlus4D(pcPlus4D), .opD(opD), .functD(functD),
        .validD(validD)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h2008_0005;
            32'h0000_0008: mem = 32'h1000_0003;
            32'h0000_0040: mem = 32'h2009_0040;
            32'h1000_0000: mem = 32'h0800_0010;
            default:       mem = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign imemRd = mem(imemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic expect_if_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pp4, input logic valid);
        logic [31:0] op_e, fn_e;
        op_e = {26'd0, instr[31:26]};
        fn_e = {26'd0, instr[5:0]};
        check_eq({tag, ".pcF"}, pcF, pc);
        check_eq({tag, ".imemAddr"}, imemAddr, pc);
        check_eq({tag, ".instrD"}, instrD, instr);
        check_eq({tag, ".pcPlus4D"}, pcPlus4D, pp4);
        check_eq({tag, ".validD"}, {31'd0, validD}, {31'd0, valid});
        check_eq({tag, ".opD"}, {26'd0, opD}, op_e);
        check_eq({tag, ".functD"}, {26'd0, functD}, fn_e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; stallF = 1'b0; stallD = 1'b0; pcSrcD = 1'b0; jumpD = 1'b0;
        pcBranchD = 32'h0;
        #12;
        expect_if_id("reset", RPC, NOP, 32'h0, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        check_eq("c0.pcF", pcF, RPC);
        step();
        expect_if_id("c1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

        // steer to the top of the address space and walk across the wrap
        pcSrcD = 1'b1; pcBranchD = 32'hFFFF_FFF8;
        step();
        expect_if_id("to_wrap", 32'hFFFF_FFF8, DS ? mem(32'h4) : NOP, DS ? 32'h8 : 32'h0, DS);
        pcSrcD = 1'b0;
        step(); expect_if_id("w1", 32'hFFFF_FFFC, mem(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b1);
        step(); expect_if_id("w2", 32'h0000_0000, mem(32'hFFFF_FFFC), 32'h0000_0000, 1'b1);
        step(); expect_if_id("w3", 32'h0000_0004, mem(32'h0), 32'h0000_0004, 1'b1);
        step(); expect_if_id("w4", 32'h0000_0008, mem(32'h4), 32'h0000_0008, 1'b1);
        step(); expect_if_id("beq_id", 32'h0000_000C, mem(32'h8), 32'h0000_000C, 1'b1);

        pcSrcD = 1'b1; pcBranchD = 32'h40;
        step();
        expect_if_id("beq_tk", 32'h40, DS ? mem(32'hC) : NOP, DS ? 32'h10 : 32'h0, DS);
        pcSrcD = 1'b0;
        step(); expect_if_id("beq_tgt", 32'h44, mem(32'h40), 32'h44, 1'b1);

        // redirect held off by a joint stall, then taken once the stall clears
        stallF = 1'b1; stallD = 1'b1; pcSrcD = 1'b1; pcBranchD = 32'h100;
        step(); expect_if_id("stall1", 32'h44, mem(32'h40), 32'h44, 1'b1);
        step(); expect_if_id("stall2", 32'h44, mem(32'h40), 32'h44, 1'b1);
        stallF = 1'b0; stallD = 1'b0;
        step();
        expect_if_id("stall_rel", 32'h100, DS ? mem(32'h44) : NOP, DS ? 32'h48 : 32'h0, DS);

        pcBranchD = 32'h1000_0000;
        step();
        expect_if_id("to_j", 32'h1000_0000, DS ? mem(32'h100) : NOP, DS ? 32'h104 : 32'h0, DS);
        pcSrcD = 1'b0;
        step(); expect_if_id("j_id", 32'h1000_0004, 32'h0800_0010, 32'h1000_0004, 1'b1);

        jumpD = 1'b1; pcSrcD = 1'b1; pcBranchD = 32'h200;
        step();
        expect_if_id("j_tk", 32'h1000_0040, DS ? mem(32'h1000_0004) : NOP,
                     DS ? 32'h1000_0008 : 32'h0, DS);
        jumpD = 1'b0; pcSrcD = 1'b0;
        step(); expect_if_id("j_tgt", 32'h1000_0044, mem(32'h1000_0040), 32'h1000_0044, 1'b1);

        // PC held while ID keeps advancing: the same word is re-latched
        stallF = 1'b1;
        step(); expect_if_id("sf1", 32'h1000_0044, mem(32'h1000_0044), 32'h1000_0048, 1'b1);
        step(); expect_if_id("sf2", 32'h1000_0044, mem(32'h1000_0044), 32'h1000_0048, 1'b1);
        stallF = 1'b0;
        step(); expect_if_id("sf_rel", 32'h1000_0048, mem(32'h1000_0044), 32'h1000_0048, 1'b1);

        // asynchronous reset in mid-cycle during a stall
        stallF = 1'b1; stallD = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        expect_if_id("async_rst", RPC, NOP, 32'h0, 1'b0);
        @(negedge clk);
        rstN = 1'b1; stallF = 1'b0; stallD = 1'b0;
        step();
        expect_if_id("post_rst", 32'h4, mem(RPC), 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
